// File: rtl/router_pkt_tx_if.sv
// Handshake and byte-stream signals between the upstream payload source,
// the packet transmitter and the downstream router port.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic       abort;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_idle;
    logic       done;
    logic       err;

    modport slave (
        input  start, dest_addr, pay_len, pay_data, pay_valid, abort, busy,
        output pay_ready, data_out, pkt_valid, tx_idle, done, err
    );

    modport master (
        output start, dest_addr, pay_len, pay_data, pay_valid, abort, busy,
        input  pay_ready, data_out, pkt_valid, tx_idle, done, err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and an
// XOR parity byte to the router, honouring its busy back-pressure.
module router_pkt_tx (
    input  logic              clk,
    input  logic              resetn,
    router_pkt_tx_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] wr_cnt_q, wr_cnt_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic       gap_cnt_q, gap_cnt_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       pay_ready_q, pay_ready_d;
    logic       tx_idle_q, tx_idle_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] mem_q [64];
    logic       mem_we;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        parity_d    = parity_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        pay_ready_d = pay_ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dest_addr != 2'd3 && bus.pay_len != 6'd0) begin
                        addr_d      = bus.dest_addr;
                        len_d       = bus.pay_len;
                        parity_d    = 8'h00;
                        wr_cnt_d    = 6'd0;
                        rd_cnt_d    = 6'd0;
                        pay_ready_d = 1'b1;
                        state_d     = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.pay_valid) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (wr_cnt_q == len_q - 6'd1) begin
                        pay_ready_d = 1'b0;
                        pkt_valid_d = 1'b1;
                        data_out_d  = {len_q, addr_q};
                        parity_d    = {len_q, addr_q};
                        state_d     = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!bus.busy) begin
                    data_out_d = mem_q[6'd0];
                    rd_cnt_d   = 6'd0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // data_out_q holds the byte being consumed, so it folds straight into parity
                if (!bus.busy) begin
                    parity_d = parity_q ^ data_out_q;
                    if (rd_cnt_q == len_q - 6'd1) begin
                        pkt_valid_d = 1'b0;
                        data_out_d  = parity_q ^ data_out_q;
                        state_d     = PARITY;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + 6'd1;
                        data_out_d = mem_q[rd_cnt_q + 6'd1];
                    end
                end
            end
            PARITY: begin
                if (!bus.busy) begin
                    data_out_d = 8'h00;
                    gap_cnt_d  = 1'b0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q && !bus.busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d     = IDLE;
            pkt_valid_d = 1'b0;
            pay_ready_d = 1'b0;
            data_out_d  = 8'h00;
            done_d      = 1'b0;
            mem_we      = 1'b0;
        end

        tx_idle_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wr_cnt_q    <= 6'd0;
            rd_cnt_q    <= 6'd0;
            gap_cnt_q   <= 1'b0;
            parity_q    <= 8'h00;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            pay_ready_q <= 1'b0;
            tx_idle_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            parity_q    <= parity_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            pay_ready_q <= pay_ready_d;
            tx_idle_q   <= tx_idle_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Payload store is never cleared; every packet rewrites all entries it reads
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_cnt_q] <= bus.pay_data;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pay_ready = pay_ready_q;
    assign bus.tx_idle   = tx_idle_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx: normal packets, back-pressure,
// rejected starts, long payloads, abort and mid-packet reset.
module tb_router_pkt_tx;

    logic clk = 1'b0;
    logic resetn;
    int   assert_count = 0;
    int   fail_count = 0;
    logic [7:0] seq [0:63];
    logic [7:0] exp_parity;

    router_pkt_tx_if bus ();

    router_pkt_tx dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] addr, input logic [5:0] len);
        bus.start     = st;
        bus.dest_addr = addr;
        bus.pay_len   = len;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_data"},  bus.data_out, 8'h00);
        checkOutput({tag, "_valid"}, bus.pkt_valid, 1'b0);
        checkOutput({tag, "_ready"}, bus.pay_ready, 1'b0);
        checkOutput({tag, "_done"},  bus.done, 1'b0);
        checkOutput({tag, "_err"},   bus.err, 1'b0);
        checkOutput({tag, "_idle"},  bus.tx_idle, 1'b1);
    endtask

    // Fills seq with header + pseudo-random payload and computes the expected parity
    task automatic build_packet(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] seed);
        seq[0] = {len, addr};
        exp_parity = seq[0];
        for (int i = 1; i <= int'(len); i++) begin
            seq[i] = seed + 8'(i * 29);
            exp_parity = exp_parity ^ seq[i];
        end
    endtask

    // mode: 0 normal completion, 1 abort when seq[abort_at] is presented, 2 reset during parity
    task automatic run_packet(input logic [1:0] addr, input logic [5:0] len, input int valid_every,
                              input bit junk_start, input int hold_at, input int hold_cycles,
                              input int mode, input int abort_at);
        int idx = 0;
        int cycles = 0;
        int got = 0;
        int held = 0;

        applyStimulus(1'b1, addr, len);
        checkOutput("start_idle", bus.tx_idle, 1'b0);
        checkOutput("start_ready", bus.pay_ready, 1'b1);
        checkOutput("start_done_clear", bus.done, 1'b0);

        while (idx < int'(len) && cycles < 400) begin
            bus.pay_valid = ((cycles + 1) % valid_every) == 0;
            bus.pay_data  = seq[idx + 1];
            if (junk_start) begin
                bus.start     = 1'b1;
                bus.dest_addr = 2'd2;
                bus.pay_len   = 6'd9;
            end
            tick();
            if (bus.pay_valid) idx++;
            cycles++;
        end
        bus.pay_valid = 1'b0;
        bus.start     = 1'b0;
        checkOutput("fill_count", idx, len);
        checkOutput("fill_cycles", cycles, int'(len) * valid_every);
        checkOutput("fill_ready_drop", bus.pay_ready, 1'b0);

        cycles = 0;
        while (got <= int'(len) && cycles < 1000) begin
            bus.busy = (got == hold_at) && (held < hold_cycles);
            if (bus.busy) held++;
            checkOutput("stream_valid", bus.pkt_valid, 1'b1);
            checkOutput("stream_byte", bus.data_out, seq[got]);
            if (mode == 1 && got == abort_at) begin
                bus.abort = 1'b1;
                bus.busy  = 1'b0;
                tick();
                bus.abort = 1'b0;
                checkOutput("abort_valid", bus.pkt_valid, 1'b0);
                checkOutput("abort_ready", bus.pay_ready, 1'b0);
                checkOutput("abort_idle", bus.tx_idle, 1'b1);
                checkOutput("abort_data", bus.data_out, 8'h00);
                for (int k = 0; k < 6; k++) begin
                    checkOutput("abort_no_done", bus.done, 1'b0);
                    tick();
                end
                return;
            end
            tick();
            cycles++;
            if (!bus.busy) got++;
        end
        bus.busy = 1'b0;
        checkOutput("stream_count", got, int'(len) + 1);
        checkOutput("stream_latency", cycles, int'(len) + 1 + hold_cycles);

        checkOutput("parity_valid", bus.pkt_valid, 1'b0);
        checkOutput("parity_byte", bus.data_out, exp_parity);
        if (mode == 2) begin
            resetn = 1'b0;
            tick();
            check_reset_outputs("parity_reset");
            resetn = 1'b1;
            return;
        end

        tick();
        checkOutput("gap1_data", bus.data_out, 8'h00);
        checkOutput("gap1_valid", bus.pkt_valid, 1'b0);
        checkOutput("gap1_done", bus.done, 1'b0);
        tick();
        checkOutput("gap2_done", bus.done, 1'b0);
        checkOutput("gap2_idle", bus.tx_idle, 1'b0);
        tick();
        checkOutput("done_pulse", bus.done, 1'b1);
        checkOutput("done_idle", bus.tx_idle, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn        = 1'b0;
        bus.start     = 1'b0;
        bus.dest_addr = 2'd0;
        bus.pay_len   = 6'd0;
        bus.pay_data  = 8'h00;
        bus.pay_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.busy      = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("idle_abort_ignored", bus.tx_idle, 1'b1);

        // Hand-computed packet: addr 1, len 3 gives header 0x0D and parity 0x0D
        seq[0] = 8'h0D;
        seq[1] = 8'h11;
        seq[2] = 8'h22;
        seq[3] = 8'h33;
        exp_parity = 8'h0D;
        run_packet(2'd1, 6'd3, 1, 1'b0, -1, 0, 0, -1);

        // Same packet again, started in the done cycle, with a stall on the first payload byte
        run_packet(2'd1, 6'd3, 1, 1'b1, 1, 3, 0, -1);
        tick();

        applyStimulus(1'b1, 2'd3, 6'd5);
        checkOutput("err_addr_pulse", bus.err, 1'b1);
        checkOutput("err_addr_idle", bus.tx_idle, 1'b1);
        checkOutput("err_addr_valid", bus.pkt_valid, 1'b0);
        tick();
        checkOutput("err_addr_clear", bus.err, 1'b0);
        applyStimulus(1'b1, 2'd1, 6'd0);
        checkOutput("err_len_pulse", bus.err, 1'b1);
        checkOutput("err_len_idle", bus.tx_idle, 1'b1);
        checkOutput("err_len_ready", bus.pay_ready, 1'b0);
        tick();
        checkOutput("err_len_clear", bus.err, 1'b0);
        checkOutput("err_len_valid", bus.pkt_valid, 1'b0);

        build_packet(2'd2, 6'd63, 8'h5A);
        run_packet(2'd2, 6'd63, 2, 1'b0, -1, 0, 0, -1);
        tick();

        build_packet(2'd0, 6'd4, 8'hC3);
        run_packet(2'd0, 6'd4, 1, 1'b0, -1, 0, 1, 3);
        build_packet(2'd1, 6'd5, 8'h07);
        run_packet(2'd1, 6'd5, 1, 1'b0, -1, 0, 0, -1);
        tick();

        build_packet(2'd2, 6'd2, 8'hE1);
        run_packet(2'd2, 6'd2, 1, 1'b0, -1, 0, 2, -1);
        build_packet(2'd0, 6'd1, 8'h99);
        run_packet(2'd0, 6'd1, 1, 1'b0, 1, 2, 0, -1);
        tick();
        checkOutput("final_done_clear", bus.done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
